// File: rtl/stage4_mem.sv
// MEM stage of the 16-bit 5-stage pipeline: EX/MEM register plus req/ack handshake to a variable-latency data memory.
// Optional build macro MEM_PERF_CNT_EN enables the perf_mem_ops / perf_stall_cycles counters.
module stage4_mem #(
    parameter int unsigned ADDR_W = 16,
    localparam int unsigned DATA_W = 16,
    localparam int unsigned REG_W  = 2,
    localparam int unsigned SRC_W  = 2,
    localparam int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [DATA_W-1:0] PcVal,
    input  logic [REG_W-1:0]  RegWriteTarget,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [SRC_W-1:0]  RegWriteSrc,
    input  logic              RegWrite,
    output logic              d_req,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_address,
    output logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_rdata,
    input  logic              d_ack,
    output logic              Stall_OUT,
    output logic [DATA_W-1:0] ALUResult_OUT,
    output logic [DATA_W-1:0] MemData_OUT,
    output logic [DATA_W-1:0] PcVal_OUT,
    output logic [REG_W-1:0]  RegWriteTarget_OUT,
    output logic [SRC_W-1:0]  RegWriteSrc_OUT,
    output logic              RegWrite_OUT,
    output logic [DATA_W-1:0] MEM_RegWriteData,
    output logic              MEM_RegWrite,
    output logic [REG_W-1:0]  MEM_Rd,
    output logic [CNT_W-1:0]  perf_mem_ops,
    output logic [CNT_W-1:0]  perf_stall_cycles
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] storeData;
        logic [DATA_W-1:0] pcVal;
        logic [REG_W-1:0]  rd;
        logic              memRead;
        logic              memWrite;
        logic [SRC_W-1:0]  src;
        logic              regWrite;
    } exmem_t;

    state_t            state;
    state_t            stateNext;
    exmem_t            exMemReg;
    exmem_t            exMemIn;
    logic [DATA_W-1:0] memDataReg;
    logic              accessDone;

    assign exMemIn = '{
        aluResult: ALUOut,
        storeData: StoreData,
        pcVal:     PcVal,
        rd:        RegWriteTarget,
        memRead:   MemRead,
        memWrite:  MemWrite,
        src:       RegWriteSrc,
        regWrite:  RegWrite
    };

    assign accessDone = (state == ACCESS) && d_ack;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: the instruction being latched decides whether a memory access follows
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (d_ack) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs decoded from state and the EX/MEM register; ACCESS turns the WB slot into a bubble
    always_comb begin
        Stall_OUT    = 1'b0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_address    = '0;
        d_wdata      = '0;
        RegWrite_OUT = 1'b0;
        MEM_RegWrite = 1'b0;
        case (state)
            IDLE: begin
                RegWrite_OUT = exMemReg.regWrite;
                MEM_RegWrite = exMemReg.regWrite;
            end
            ACCESS: begin
                Stall_OUT = 1'b1;
                d_req     = 1'b1;
                d_we      = exMemReg.memWrite;
                d_address = ADDR_W'(exMemReg.aluResult);
                d_wdata   = exMemReg.storeData;
            end
            default: begin
                Stall_OUT = 1'b0;
            end
        endcase
    end

    // EX/MEM register and load-data capture; a write wins when both controls are set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exMemReg   <= '0;
            memDataReg <= '0;
        end else begin
            if (state == IDLE) begin
                exMemReg <= exMemIn;
            end
            if (accessDone && exMemReg.memRead && !exMemReg.memWrite) begin
                memDataReg <= d_rdata;
            end
        end
    end

    // Forwarding value selected by writeback source
    always_comb begin
        MEM_RegWriteData = exMemReg.aluResult;
        case (exMemReg.src)
            2'd1:    MEM_RegWriteData = memDataReg;
            2'd2:    MEM_RegWriteData = exMemReg.pcVal;
            default: MEM_RegWriteData = exMemReg.aluResult;
        endcase
    end

    assign ALUResult_OUT      = exMemReg.aluResult;
    assign MemData_OUT        = memDataReg;
    assign PcVal_OUT          = exMemReg.pcVal;
    assign RegWriteTarget_OUT = exMemReg.rd;
    assign RegWriteSrc_OUT    = exMemReg.src;
    assign MEM_Rd             = exMemReg.rd;

`ifdef MEM_PERF_CNT_EN
    logic [CNT_W-1:0] perfOpsReg;
    logic [CNT_W-1:0] perfStallReg;

    // Saturating counters of completed accesses and stalled cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perfOpsReg   <= '0;
            perfStallReg <= '0;
        end else begin
            if ((state == ACCESS) && (perfStallReg != '1)) begin
                perfStallReg <= perfStallReg + CNT_W'(1);
            end
            if (accessDone && (perfOpsReg != '1)) begin
                perfOpsReg <= perfOpsReg + CNT_W'(1);
            end
        end
    end

    assign perf_mem_ops      = perfOpsReg;
    assign perf_stall_cycles = perfStallReg;
`else
    assign perf_mem_ops      = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
